alu_operand_stage: RTL and testbench

Operand-fetch stage directly upstream of the 32-bit ALU. It holds the 32-entry architectural register file and accepts one decoded operation per handshake. For each accepted operation it reads the source registers, or selects the immediate for operand b, and presents registered `a`, `b` and `control` to the ALU. A pending-write scoreboard stalls operations whose sources are still awaiting writeback from downstream.

---
 rtl/alu_operand_stage_pkg.sv | 26 ++
 rtl/alu_operand_stage_if.sv | 37 +++
 rtl/alu_operand_stage_register_file.sv | 44 ++++
 rtl/alu_operand_stage.sv | 87 ++++++++
 tb/tb_alu_operand_stage.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/alu_operand_stage_pkg.sv
// Shared types and constants for the ALU operand-fetch stage.
package alu_operand_stage_pkg;

    localparam int N    = 32;
    localparam int REGS = 32;
    localparam int A    = 5;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SLL = 4'b0011,
        ALU_SRL = 4'b0100,
        ALU_SRA = 4'b0101,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111,
        ALU_XOR = 4'b1000
    } alu_control_t;

    typedef logic [A-1:0] reg_addr_t;
    typedef logic [N-1:0] data_t;

    localparam reg_addr_t   REG_ZERO = 5'd0;
    localparam logic [3:0]  ALU_NOP  = 4'b0000;

endpackage

// File: rtl/alu_operand_stage_if.sv
// Decoded-op input, ALU-operand output and writeback bundle of the operand stage.
interface alu_operand_stage_if;
    import alu_operand_stage_pkg::*;

    logic         in_valid;
    logic         in_ready;
    reg_addr_t    rs1;
    reg_addr_t    rs2;
    data_t        imm;
    logic         use_imm;
    alu_control_t control;
    reg_addr_t    rd;

    logic         out_valid;
    logic         out_ready;
    data_t        alu_a;
    data_t        alu_b;
    alu_control_t alu_control;
    reg_addr_t    out_rd;

    logic         wr_ena;
    reg_addr_t    wr_addr;
    data_t        wr_data;

    modport slave (
        input  in_valid, rs1, rs2, imm, use_imm, control, rd,
        input  out_ready, wr_ena, wr_addr, wr_data,
        output in_ready, out_valid, alu_a, alu_b, alu_control, out_rd
    );

    modport master (
        output in_valid, rs1, rs2, imm, use_imm, control, rd,
        output out_ready, wr_ena, wr_addr, wr_data,
        input  in_ready, out_valid, alu_a, alu_b, alu_control, out_rd
    );

endinterface

// File: rtl/alu_operand_stage_register_file.sv
// 32x32 register file: two combinational read ports with x0-zero and same-cycle
// write forwarding, one synchronous write port; synchronous active-low clear.
module register_file
    import alu_operand_stage_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  reg_addr_t i_rd_addr_a,
    output data_t     o_rd_data_a,
    input  reg_addr_t i_rd_addr_b,
    output data_t     o_rd_data_b,
    input  logic      i_wr_ena,
    input  reg_addr_t i_wr_addr,
    input  data_t     i_wr_data
);

    data_t r_mem [REGS];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < REGS; i++) r_mem[i] <= '0;
        end else if (i_wr_ena && i_wr_addr != REG_ZERO) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Forwarding lets an op accepted in the writeback cycle see the new value.
    always_comb begin
        o_rd_data_a = r_mem[i_rd_addr_a];
        if (i_rd_addr_a == REG_ZERO)
            o_rd_data_a = '0;
        else if (i_wr_ena && i_wr_addr == i_rd_addr_a)
            o_rd_data_a = i_wr_data;
    end

    always_comb begin
        o_rd_data_b = r_mem[i_rd_addr_b];
        if (i_rd_addr_b == REG_ZERO)
            o_rd_data_b = '0;
        else if (i_wr_ena && i_wr_addr == i_rd_addr_b)
            o_rd_data_b = i_wr_data;
    end

endmodule

// File: rtl/alu_operand_stage.sv
// Operand fetch ahead of the ALU: register read / immediate select, pending-write
// scoreboard stall, single registered output slot (1-cycle latency, no skid).
module alu_operand_stage
    import alu_operand_stage_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    alu_operand_stage_if.slave  bus
);

    logic [REGS-1:0] r_pend;
    logic [REGS-1:0] w_pend_nxt;
    logic            r_out_valid;
    data_t           r_alu_a;
    data_t           r_alu_b;
    alu_control_t    r_alu_control;
    reg_addr_t       r_out_rd;

    data_t           w_rs1_val;
    data_t           w_rs2_val;
    logic            w_hz_rs1;
    logic            w_hz_rs2;
    logic            w_in_ready;
    logic            w_accept;

    register_file u_register_file (
        .clk         (clk),
        .rst         (rst),
        .i_rd_addr_a (bus.rs1),
        .o_rd_data_a (w_rs1_val),
        .i_rd_addr_b (bus.rs2),
        .o_rd_data_b (w_rs2_val),
        .i_wr_ena    (bus.wr_ena),
        .i_wr_addr   (bus.wr_addr),
        .i_wr_data   (bus.wr_data)
    );

    // A same-cycle writeback resolves the hazard because the read port forwards it.
    always_comb begin
        w_hz_rs1   = r_pend[bus.rs1] && (bus.rs1 != REG_ZERO)
                     && !(bus.wr_ena && bus.wr_addr == bus.rs1);
        w_hz_rs2   = !bus.use_imm && r_pend[bus.rs2] && (bus.rs2 != REG_ZERO)
                     && !(bus.wr_ena && bus.wr_addr == bus.rs2);
        w_in_ready = (!r_out_valid || bus.out_ready) && !w_hz_rs1 && !w_hz_rs2;
        w_accept   = bus.in_valid && w_in_ready;
    end

    // Clear first, then set, so an accept targeting a register being written back stays pending.
    always_comb begin
        w_pend_nxt = r_pend;
        if (bus.wr_ena)
            w_pend_nxt[bus.wr_addr] = 1'b0;
        if (w_accept && bus.rd != REG_ZERO)
            w_pend_nxt[bus.rd] = 1'b1;
        w_pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pend        <= '0;
            r_out_valid   <= 1'b0;
            r_alu_a       <= '0;
            r_alu_b       <= '0;
            r_alu_control <= alu_control_t'(ALU_NOP);
            r_out_rd      <= REG_ZERO;
        end else begin
            r_pend <= w_pend_nxt;
            if (w_accept) begin
                r_out_valid   <= 1'b1;
                r_alu_a       <= w_rs1_val;
                r_alu_b       <= bus.use_imm ? bus.imm : w_rs2_val;
                r_alu_control <= bus.control;
                r_out_rd      <= bus.rd;
            end else if (bus.out_ready) begin
                r_out_valid   <= 1'b0;
            end
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.out_valid   = r_out_valid;
    assign bus.alu_a       = r_alu_a;
    assign bus.alu_b       = r_alu_b;
    assign bus.alu_control = r_alu_control;
    assign bus.out_rd      = r_out_rd;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a behavioural model.
module tb_alu_operand_stage;
    import alu_operand_stage_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    alu_operand_stage_if bus ();

    alu_operand_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    logic [31:0] m_mem [32];
    logic [31:0] m_pend;
    bit          m_init = 0;
    bit          m_v;
    logic [31:0] m_a, m_b;
    logic [3:0]  m_c;
    logic [4:0]  m_rd;

    alu_control_t ops [9] = '{ALU_AND, ALU_OR, ALU_ADD, ALU_SLL, ALU_SRL,
                              ALU_SRA, ALU_SUB, ALU_SLT, ALU_XOR};

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_read(logic [4:0] a);
        if (a == 0) return 32'h0;
        if (bus.wr_ena && bus.wr_addr == a) return bus.wr_data;
        return m_mem[a];
    endfunction

    function automatic bit m_waiting(logic [4:0] s);
        return (s != 0) && m_pend[s] && !(bus.wr_ena && bus.wr_addr == s);
    endfunction

    function automatic bit m_ready();
        return (!m_v || bus.out_ready) && !m_waiting(bus.rs1)
               && !(!bus.use_imm && m_waiting(bus.rs2));
    endfunction

    task automatic model_step();
        bit acc;
        if (!rst) begin
            for (int i = 0; i < 32; i++) m_mem[i] = 32'h0;
            m_pend = 32'h0;
            m_v = 0; m_a = 0; m_b = 0; m_c = 4'h0; m_rd = 5'd0;
            m_init = 1;
        end else begin
            acc = bus.in_valid && m_ready();
            if (acc) begin
                m_a  = m_read(bus.rs1);
                m_b  = bus.use_imm ? bus.imm : m_read(bus.rs2);
                m_c  = bus.control;
                m_rd = bus.rd;
                m_v  = 1;
            end else if (bus.out_ready) begin
                m_v = 0;
            end
            if (bus.wr_ena) m_pend[bus.wr_addr] = 1'b0;
            if (acc && bus.rd != 0) m_pend[bus.rd] = 1'b1;
            if (bus.wr_ena && bus.wr_addr != 0) m_mem[bus.wr_addr] = bus.wr_data;
        end
    endtask

    // One clock: compare DUT to model at the falling edge, advance model at the rising edge.
    task automatic tick();
        @(negedge clk);
        if (m_init) begin
            chk("cyc_in_ready", {31'b0, bus.in_ready}, {31'b0, m_ready()});
            chk("cyc_out_valid", {31'b0, bus.out_valid}, {31'b0, m_v});
            if (m_v) begin
                chk("cyc_alu_a", bus.alu_a, m_a);
                chk("cyc_alu_b", bus.alu_b, m_b);
                chk("cyc_alu_control", {28'b0, bus.alu_control}, {28'b0, m_c});
                chk("cyc_out_rd", {27'b0, bus.out_rd}, {27'b0, m_rd});
            end
        end
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        bus.in_valid = 0; bus.rs1 = 0; bus.rs2 = 0; bus.imm = 0; bus.use_imm = 0;
        bus.control = ALU_AND; bus.rd = 0; bus.out_ready = 1;
        bus.wr_ena = 0; bus.wr_addr = 0; bus.wr_data = 0;
    endtask

    task automatic op(logic [4:0] r1, logic [4:0] r2, bit ui, logic [31:0] im,
                      alu_control_t c, logic [4:0] d);
        bus.in_valid = 1; bus.rs1 = r1; bus.rs2 = r2; bus.use_imm = ui;
        bus.imm = im; bus.control = c; bus.rd = d;
    endtask

    task automatic wr(logic [4:0] a, logic [31:0] d);
        bus.wr_ena = 1; bus.wr_addr = a; bus.wr_data = d;
    endtask

    initial begin
        idle();
        rst = 0;
        tick(); tick();
        rst = 1;
        #1;
        // Reset state
        chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("rst_alu_a", bus.alu_a, 32'd0);
        chk("rst_alu_b", bus.alu_b, 32'd0);
        chk("rst_alu_control", {28'b0, bus.alu_control}, 32'd0);
        chk("rst_out_rd", {27'b0, bus.out_rd}, 32'd0);
        chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);

        // x0 discards writes
        wr(5'd0, 32'hDEADBEEF); tick(); idle();
        op(5'd0, 5'd0, 1, 32'h1, ALU_ADD, 5'd0); tick(); idle();
        chk("x0_alu_a", bus.alu_a, 32'h0);
        chk("x0_out_valid", {31'b0, bus.out_valid}, 32'd1);

        // Basic read with immediate
        wr(5'd5, 32'h10); tick(); idle();
        op(5'd5, 5'd0, 1, 32'h3, ALU_ADD, 5'd0); tick(); idle();
        chk("basic_alu_a", bus.alu_a, 32'h10);
        chk("basic_alu_b", bus.alu_b, 32'h3);
        chk("basic_alu_control", {28'b0, bus.alu_control}, {28'b0, ALU_ADD});

        // Same-cycle writeback forwarding
        wr(5'd7, 32'h55); op(5'd7, 5'd7, 0, 32'h0, ALU_SUB, 5'd0); tick(); idle();
        chk("fwd_alu_a", bus.alu_a, 32'h55);
        chk("fwd_alu_b", bus.alu_b, 32'h55);

        // Backpressure: output held, later write to the source ignored by held operands
        bus.out_ready = 0; op(5'd5, 5'd0, 1, 32'h9, ALU_OR, 5'd0); #1;
        chk("bp_in_ready", {31'b0, bus.in_ready}, 32'd0);
        tick();
        wr(5'd7, 32'h99); wr(5'd5, 32'h99); tick(); bus.wr_ena = 0;
        tick();
        chk("bp_held_a", bus.alu_a, 32'h55);
        chk("bp_held_valid", {31'b0, bus.out_valid}, 32'd1);
        bus.out_ready = 1; #1;
        chk("bp_release_ready", {31'b0, bus.in_ready}, 32'd1);
        tick(); bus.in_valid = 0;
        chk("bp_new_a", bus.alu_a, 32'h99);
        chk("bp_new_b", bus.alu_b, 32'h9);
        tick();
        chk("bp_one_consumed", {31'b0, bus.out_valid}, 32'd0);

        // Scoreboard stall on rd=9
        op(5'd0, 5'd0, 1, 32'h0, ALU_ADD, 5'd9); tick();
        op(5'd9, 5'd0, 1, 32'h1, ALU_ADD, 5'd0); #1;
        chk("sb_stall", {31'b0, bus.in_ready}, 32'd0);
        tick();
        chk("sb_stall2", {31'b0, bus.in_ready}, 32'd0);
        wr(5'd9, 32'h77); #1;
        chk("sb_wb_ready", {31'b0, bus.in_ready}, 32'd1);
        tick(); idle();
        chk("sb_alu_a", bus.alu_a, 32'h77);

        // Set/clear collision on x4: set wins
        wr(5'd4, 32'h44); op(5'd0, 5'd0, 1, 32'h0, ALU_ADD, 5'd4); tick(); idle();
        op(5'd4, 5'd0, 1, 32'h0, ALU_ADD, 5'd0); #1;
        chk("coll_stall", {31'b0, bus.in_ready}, 32'd0);
        tick();
        wr(5'd4, 32'h45); tick(); idle();
        chk("coll_alu_a", bus.alu_a, 32'h45);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.rs1       = 5'($urandom_range(0, 7));
            bus.rs2       = 5'($urandom_range(0, 7));
            bus.use_imm   = $urandom_range(0, 1) == 1;
            bus.imm       = $urandom;
            bus.control   = ops[$urandom_range(0, 8)];
            bus.rd        = 5'($urandom_range(0, 7));
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.wr_ena    = ($urandom_range(0, 9) < 4);
            bus.wr_addr   = 5'($urandom_range(0, 7));
            bus.wr_data   = $urandom;
            tick();
        end

        // Reset mid-operation with a held output and a write in flight
        bus.out_ready = 0; op(5'd1, 5'd2, 0, 32'h0, ALU_ADD, 5'd3); wr(5'd6, 32'h1234);
        tick();
        rst = 0; tick(); rst = 1; idle();
        #1;
        chk("mid_rst_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("mid_rst_ready", {31'b0, bus.in_ready}, 32'd1);
        op(5'd6, 5'd5, 0, 32'h0, ALU_ADD, 5'd0); tick(); idle();
        chk("mid_rst_a", bus.alu_a, 32'h0);
        chk("mid_rst_b", bus.alu_b, 32'h0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
